lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Load/store initiator driving the word-addressed data memory (mem_we/mem_a/mem_wd/mem_rd).
//  Accepts RV32I load/store requests from the pipeline and performs sub-word handling:
//  byte/half extraction with sign/zero extension, read-modify-write for SB/SH.
//  Flags misaligned, illegal-funct3 and out-of-range accesses without touching memory.
// PARAMETERS
//  MEM_DEPTH  1024  words in the data memory; word index addr[31:2] must be < MEM_DEPTH
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst            in   1   asynchronous reset, active-low
//  req_valid      in   1   request present
//  req_ready      out  1   block can accept (high only in IDLE)
//  req_we         in   1   1=store, 0=load
//  req_funct3     in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data (low byte/half used for SB/SH)
//  rsp_valid      out  1   one-cycle response pulse
//  rsp_rdata      out  32  extended load data (0 for stores/errors)
//  rsp_err        out  1   misaligned, illegal funct3 or out-of-range; valid with rsp_valid
//  mem_we         out  1   memory write enable (memory writes on posedge)
//  mem_a          out  32  word index = addr[31:2], zero-extended
//  mem_wd         out  32  memory write data
//  mem_rd         in   32  memory read data, combinational from mem_a
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_a=0,
//   mem_wd=0, latched request cleared. Reset mid-operation abandons access; no write is issued.
//  Handshake: accept when req_valid && req_ready at posedge; request fields latched then.
//   Requests while busy are not accepted; requester holds them. req_ready is 0 in all non-IDLE states.
//  Error check at accept: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; loads funct3 in
//   {0,1,2,4,5}, stores in {0,1,2}; addr[31:2] >= MEM_DEPTH is error. Error -> ERR.
//  FSM:
//   IDLE   -> ERR (error) | LOAD (load) | WRITE (SW) | RMW_RD (SB/SH)
//   LOAD   mem_a driven; mem_rd lane-selected by addr[1:0], sign/zero extended, registered -> RESP
//   RMW_RD mem_a driven; mem_rd captured with byte/half lane replaced by req_wdata -> WRITE
//   WRITE  mem_we=1 for exactly this cycle, mem_wd = merged word (SW: req_wdata) -> RESP
//   RESP   rsp_valid=1, rsp_err=0 -> IDLE
//   ERR    rsp_valid=1, rsp_err=1, rsp_rdata=0, no memory access -> IDLE
//  Latency from accept edge T: error resp at T+1; load/SW resp at T+2; SB/SH resp at T+3.
//  mem_we is 0 in every state except WRITE; mem_a holds latched index while busy.
//  Lanes: byte k = bits [8k+7:8k] for addr[1:0]=k; half uses addr[1] (0 -> [15:0], 1 -> [31:16]).
//  Back-to-back: new request may be accepted the cycle after RESP/ERR (in IDLE).
// TESTING
//  SW 0x12345678 @0x10 then LW @0x10 -> mem_we pulse 1 cycle, mem_a=4; LW rsp_rdata=0x12345678 at T+2.
//  Word 0x12345678 @0x10; SB 0xAB @0x11 -> mem_wd=0x1234AB78 at T+2; LB @0x11 -> 0xFFFFFFAB, LBU -> 0x000000AB.
//  SH 0x8001 @0x12 over 0x1234AB78 -> 0x8001AB78; LH @0x12 -> 0xFFFF8001; LHU -> 0x00008001.
//  LW @0x13, SH @0x01, funct3=3 load, LW @0x1000 -> rsp_err=1 at T+1, mem_we never asserts, memory unchanged.
//  rst=0 asserted in RMW_RD of SB -> outputs zero immediately, no write; after release req_ready=1.
//  Back-to-back SW/LW with req_valid held high -> each accepted only in IDLE, responses in order.

Source files
------------

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - RV32I load/store initiator with sub-word extract and read-modify-write
module lsu_mem_master #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP,
        S_ERR
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    state_t      state, state_nxt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        acc;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready = (state == S_IDLE);
    assign acc       = req_valid && req_ready;
    assign mem_we    = (state == S_WRITE);
    assign rsp_valid = (state == S_RESP) || (state == S_ERR);
    assign rsp_err   = (state == S_ERR);

    // Alignment, funct3 legality and range are all decided on the unlatched request.
    always_comb begin
        req_err = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'd0:    req_err = 1'b0;
                3'd1:    req_err = req_addr[0];
                3'd2:    req_err = |req_addr[1:0];
                default: req_err = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'd0, 3'd4: req_err = 1'b0;
                3'd1, 3'd5: req_err = req_addr[0];
                3'd2:       req_err = |req_addr[1:0];
                default:    req_err = 1'b1;
            endcase
        end
        if ({2'b00, req_addr[31:2]} >= DEPTH_W) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        byte_sel = mem_rd[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (f3_q)
            3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_ext = {24'h0, byte_sel};
            3'd5:    load_ext = {16'h0, half_sel};
            default: load_ext = mem_rd;
        endcase
    end

    always_comb begin
        merged = mem_rd;
        case (f3_q)
            3'd0: merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            3'd1: begin
                if (off_q[1]) merged[31:16] = wdata_q[15:0];
                else          merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    if (req_err)                 state_nxt = S_ERR;
                    else if (!req_we)            state_nxt = S_LOAD;
                    else if (req_funct3 == 3'd2) state_nxt = S_WRITE;
                    else                         state_nxt = S_RMW_RD;
                end
            end
            S_LOAD:   state_nxt = S_RESP;
            S_RMW_RD: state_nxt = S_WRITE;
            S_WRITE:  state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            wdata_q   <= 32'h0;
            mem_a     <= 32'h0;
            mem_wd    <= 32'h0;
            rsp_rdata <= 32'h0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                f3_q      <= req_funct3;
                off_q     <= req_addr[1:0];
                wdata_q   <= req_wdata;
                mem_a     <= {2'b00, req_addr[31:2]};
                rsp_rdata <= 32'h0;
                if (req_we && (req_funct3 == 3'd2) && !req_err) begin
                    mem_wd <= req_wdata;
                end
            end
            if (state == S_LOAD) begin
                rsp_rdata <= load_ext;
            end
            if (state == S_RMW_RD) begin
                mem_wd <= merged;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - scoreboard bench for lsu_mem_master against a word-array memory model
module tb_lsu_mem_master;

    localparam int MEM_DEPTH = 1024;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } rsp_t;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] dmem    [MEM_DEPTH];
    logic [31:0] ref_mem [MEM_DEPTH];
    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    int          cyc;
    int          checks;
    int          failures;

    lsu_mem_master #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = (mem_a < 32'(MEM_DEPTH)) ? dmem[mem_a[9:0]] : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we && (mem_a < 32'(MEM_DEPTH))) dmem[mem_a[9:0]] <= mem_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: decode legality, then plain shift/mask arithmetic on the word array.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int lat, output logic wr, output logic [31:0] widx,
                         output logic [31:0] wword);
        logic [31:0] idx;
        logic [31:0] w;
        int off, b, h;
        idx = addr >> 2;
        off = int'(addr % 4);
        rd = 0; err = 0; wr = 0; widx = idx; wword = 0; lat = 2;
        if (idx >= MEM_DEPTH) err = 1;
        if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) err = 1;
        if (we && f3 > 3'd2) err = 1;
        if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) err = 1;
        if (f3 == 3'd2 && off != 0) err = 1;
        if (err) begin
            lat = 1;
            return;
        end
        w = ref_mem[idx[9:0]];
        b = int'((w >> (8 * off)) & 32'hFF);
        h = int'((w >> (16 * (off / 2))) & 32'hFFFF);
        if (!we) begin
            case (f3)
                3'd0:    rd = (b >= 128) ? 32'(b - 256) : 32'(b);
                3'd1:    rd = (h >= 32768) ? 32'(h - 65536) : 32'(h);
                3'd4:    rd = 32'(b);
                3'd5:    rd = 32'(h);
                default: rd = w;
            endcase
        end else begin
            wr = 1;
            case (f3)
                3'd0: begin
                    wword = (w & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
                    lat = 3;
                end
                3'd1: begin
                    wword = (w & ~(32'hFFFF << (16 * (off / 2)))) | ((wd & 32'hFFFF) << (16 * (off / 2)));
                    lat = 3;
                end
                default: wword = wd;
            endcase
            ref_mem[idx[9:0]] = wword;
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold);
        logic [31:0] rd, widx, wword;
        logic err, wr;
        int lat, n;
        rsp_t r;
        wr_t  w;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready) begin
            @(negedge clk);
            n++;
            if (n > 20) begin
                chk("accept_timeout", 32'(req_ready), 32'd1);
                req_valid = 1'b0;
                return;
            end
        end
        model(we, f3, addr, wd, rd, err, lat, wr, widx, wword);
        r.rdata = rd; r.err = err; r.due = cyc + lat;
        rsp_q.push_back(r);
        if (wr) begin
            w.idx = widx; w.data = wword;
            wr_q.push_back(w);
        end
        @(posedge clk);
        if (!hold) #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(rsp_q.size() + wr_q.size()), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (rsp_valid) begin
                chk("rsp_ready_low", 32'(req_ready), 32'd0);
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    chk("rsp_latency", 32'(cyc), 32'(r.due));
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    chk("mem_we_unexpected", 32'(mem_we), 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("mem_a", mem_a, w.idx);
                    chk("mem_wd", mem_wd, w.data);
                end
            end
        end
    end

    initial begin
        int bad;
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [31:0] a;
        logic [2:0]  f;
        cyc = 0; checks = 0; failures = 0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            dmem[i] = $urandom;
            ref_mem[i] = dmem[i];
        end
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_a", mem_a, 32'd0);
        chk("reset_mem_wd", mem_wd, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        issue(1, 3'd2, 32'h10, 32'h12345678, 0);
        issue(0, 3'd2, 32'h10, 32'h0, 0);
        issue(1, 3'd0, 32'h11, 32'h000000AB, 0);
        issue(0, 3'd0, 32'h11, 32'h0, 0);
        issue(0, 3'd4, 32'h11, 32'h0, 0);
        issue(1, 3'd1, 32'h12, 32'h00008001, 0);
        issue(0, 3'd1, 32'h12, 32'h0, 0);
        issue(0, 3'd5, 32'h12, 32'h0, 0);
        issue(0, 3'd2, 32'h13, 32'h0, 0);
        issue(1, 3'd1, 32'h01, 32'hFFFF, 0);
        issue(0, 3'd3, 32'h10, 32'h0, 0);
        issue(0, 3'd2, 32'h1000, 32'h0, 0);
        issue(1, 3'd2, 32'h20, 32'hCAFEF00D, 1);
        issue(0, 3'd2, 32'h20, 32'h0, 1);
        issue(1, 3'd2, 32'h24, 32'h0BADBEEF, 1);
        issue(0, 3'd0, 32'h27, 32'h0, 0);
        drain();
        chk("directed_word4", dmem[4], 32'h8001AB78);

        // Reset while the SB sits in its read phase must abandon the write.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h21; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mid_mem_a", mem_a, 32'd0);
        chk("rst_mid_mem_wd", mem_wd, 32'd0);
        chk("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_release_ready", 32'(req_ready), 32'd1);
        chk("rst_no_write", dmem[8], ref_mem[8]);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(MEM_DEPTH, MEM_DEPTH + 64)) << 2;
            else a = 32'($urandom_range(0, 31)) << 2;
            a = a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) f = 3'($urandom);
            else if ($urandom_range(0, 1) == 0) f = 3'd2;
            else f = 3'($urandom_range(0, 1));
            if (f == 3'd2 && $urandom_range(0, 2) != 0) a = a & ~32'h3;
            if (f != 3'd2 && $urandom_range(0, 1) == 0) a = a & ~32'h1;
            if ($urandom_range(0, 1) == 1 && f <= 3'd1) f = f + 3'd4;
            issue(1'($urandom), f, a, $urandom, 1'($urandom));
        end
        drain();

        bad = 0;
        for (int i = 0; i < MEM_DEPTH; i++) if (dmem[i] !== ref_mem[i]) bad++;
        chk("final_memory_mismatch_words", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
